bus_wait_memory: RTL and testbench

Word-addressed memory slave on the CPU's 32-bit read/write/waitrequest bus. It sits directly downstream of the bus master and serves instruction fetches from the reset-vector region and data loads/stores from a low data region. It inserts a configurable number of wait states per transfer and honours byte-enables on writes. It reports protocol and address violations on a sticky error flag for the bench.

---
 rtl/bus_mem_pkg.sv | 12 +
 rtl/mem_wait_lfsr.sv | 19 +
 rtl/bus_wait_memory.sv | 160 ++++++++++++++++
 tb/tb_bus_wait_memory.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the wait-state memory slave.
package bus_mem_pkg;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef enum logic [1:0] {REG_NONE, REG_INSTR, REG_DATA} region_t;

    // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3 of the shift register.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/mem_wait_lfsr.sv
// 8-bit Fibonacci LFSR supplying per-transfer wait targets; steps once per advance pulse.
module mem_wait_lfsr
    import bus_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= {value[6:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/bus_wait_memory.sv
// Two-region word memory on a read/write/waitrequest bus with N wait states per transfer.
// Sticky bus_error on protocol/address faults; MEM_RANDOM_WAIT_EN draws N from an LFSR.
module bus_wait_memory
    import bus_mem_pkg::*;
#(
    parameter logic [31:0] INSTR_BASE  = 32'hBFC0_0000,
    parameter logic [31:0] DATA_BASE   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] REGION_SPAN = 32'(4 * DEPTH_WORDS);

    logic [31:0] instr_mem [DEPTH_WORDS];
    logic [31:0] data_mem  [DEPTH_WORDS];

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  target;
    logic [3:0]  start_target;
    logic [3:0]  cur_target;
    logic [31:0] lat_addr;
    logic        lat_rd;
    logic        lat_wr;
    logic [3:0]  lat_be;

    logic        req;
    logic        accept;
    logic        changed;
    logic        bad_addr;
    region_t     region;
    logic [AW-1:0] index;
    logic [31:0] instr_off;
    logic [31:0] data_off;

`ifdef MEM_RANDOM_WAIT_EN
    logic [7:0] lfsr_value;

    mem_wait_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .value   (lfsr_value)
    );

    assign start_target = 4'(lfsr_value % 8'(WAIT_CYCLES + 1));
`else
    assign start_target = 4'(WAIT_CYCLES);
`endif

    // Offsets wrap below the base, so a single unsigned compare covers both bounds.
    always_comb begin
        instr_off = address - INSTR_BASE;
        data_off  = address - DATA_BASE;
        region    = REG_NONE;
        index     = '0;
        if (instr_off < REGION_SPAN) begin
            region = REG_INSTR;
            index  = instr_off[AW+1:2];
        end else if (data_off < REGION_SPAN) begin
            region = REG_DATA;
            index  = data_off[AW+1:2];
        end
    end

    assign req         = read ^ write;
    assign cur_target  = (state == IDLE) ? start_target : target;
    assign waitrequest = req && (cnt < cur_target);
    assign accept      = req && !waitrequest;
    assign bad_addr    = (region == REG_NONE) || (address[1:0] != 2'b00);
    assign changed     = (address != lat_addr) || (read != lat_rd) ||
                         (write != lat_wr) || (byteenable != lat_be);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            target    <= '0;
            lat_addr  <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_be    <= '0;
            bus_error <= 1'b0;
        end else begin
            if ((read && write) || (req && bad_addr)) begin
                bus_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req && waitrequest) begin
                        cnt      <= cnt + 4'd1;
                        target   <= start_target;
                        lat_addr <= address;
                        lat_rd   <= read;
                        lat_wr   <= write;
                        lat_be   <= byteenable;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        bus_error <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        if (changed) begin
                            bus_error <= 1'b1;
                        end
                        if (waitrequest) begin
                            cnt <= cnt + 4'd1;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset; the reset gate drops a write caught by reset.
    always_ff @(posedge clk) begin
        if (!reset && accept && write) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    if (region == REG_INSTR) begin
                        instr_mem[index][8*b +: 8] <= writedata[8*b +: 8];
                    end else if (region == REG_DATA) begin
                        data_mem[index][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (accept && read) begin
            case (region)
                REG_INSTR: readdata = instr_mem[index];
                REG_DATA:  readdata = data_mem[index];
                default:   readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_wait_memory.sv
// Bench for bus_wait_memory: vector table, directed corner sequences, randomized traffic vs a word model.
module tb_bus_wait_memory;

`ifdef MEM_RANDOM_WAIT_EN
    localparam int WC = 3;
`else
    localparam int WC = 2;
`endif
    localparam logic [31:0] IB = 32'hBFC0_0000;
    localparam logic [31:0] DB = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] ref_lfsr = 8'hA5;
    bit exp_err = 1'b0;

    logic [31:0] mdl_i [16];
    logic [31:0] mdl_d [16];

    bus_wait_memory #(
        .INSTR_BASE  (IB),
        .DATA_BASE   (DB),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .bus_error   (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_wait();
`ifdef MEM_RANDOM_WAIT_EN
        return int'(ref_lfsr) % (WC + 1);
`else
        return WC;
`endif
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        read = 1'b0;
        write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ref_lfsr = 8'hA5;
        exp_err = 1'b0;
    endtask

    // Starts at a negedge; returns at the negedge after acceptance with request still driven.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd, input string tag);
        int waits;
        int want;
        want = exp_wait();
        address = a;
        read = !wr;
        write = wr;
        writedata = wd;
        byteenable = be;
        waits = 0;
        #1;
        while (waitrequest && waits < 40) begin
            waits++;
            @(negedge clk);
            #1;
        end
        check({tag, " waits"}, 32'(waits), 32'(want));
        check({tag, " readdata"}, readdata, exp_rd);
        ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
        @(negedge clk);
        check({tag, " bus_error"}, 32'(bus_error), 32'(exp_err));
    endtask

    task automatic idle();
        read = 1'b0;
        write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int sel;
        int idx;
        bit wr;
        bit bad;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0] be;
        logic [31:0] er;
        logic [31:0] old;

        tbl[0]  = '{1'b1, 32'hBFC0_0000, 32'h2402_0005, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 32'hBFC0_0000, 32'h0,         4'h0, 32'h2402_0005};
        tbl[2]  = '{1'b1, 32'h0000_1004, 32'h1122_3344, 4'hF, 32'h0};
        tbl[3]  = '{1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'b0101, 32'h0};
        tbl[4]  = '{1'b0, 32'h0000_1004, 32'h0,         4'h0, 32'h11BB_33DD};
        tbl[5]  = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[6]  = '{1'b1, 32'h0000_1000, 32'h0,         4'h0, 32'h0};
        tbl[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'hDEAD_BEEF};
        tbl[8]  = '{1'b1, 32'hBFC0_0FFC, 32'h5A5A_5A5A, 4'hF, 32'h0};
        tbl[9]  = '{1'b0, 32'hBFC0_0FFC, 32'h0,         4'h0, 32'h5A5A_5A5A};
        tbl[10] = '{1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 4'b1010, 32'h0};
        tbl[11] = '{1'b0, 32'h0000_1FFC, 32'h0,         4'h0, 32'hCAXX_F0XX};

        reset = 1'b1;
        address = '0;
        read = 1'b0;
        write = 1'b0;
        writedata = '0;
        byteenable = '0;
        @(negedge clk);
        check("reset waitrequest", 32'(waitrequest), 32'h0);
        check("reset readdata", readdata, 32'h0);
        check("reset bus_error", 32'(bus_error), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Make the last data word fully known before the partial write in the table.
        xfer(1'b1, 32'h0000_1FFC, 32'h1234_5678, 4'hF, 32'h0, "init 1ffc");
        idle();
        tbl[11].exp_rd = 32'hCA34_F078;
        for (int i = 0; i < 12; i++) begin
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp_rd,
                 $sformatf("tbl%0d", i));
            idle();
        end

`ifndef MEM_RANDOM_WAIT_EN
        exp_err = 1'b1;
        xfer(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0, "unmapped");
        idle();
        repeat (3) @(negedge clk);
        check("unmapped sticky", 32'(bus_error), 32'h1);
        apply_reset();
        check("err cleared", 32'(bus_error), 32'h0);

        exp_err = 1'b1;
        xfer(1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h0, "past data end");
        idle();
        apply_reset();

        exp_err = 1'b1;
        xfer(1'b0, 32'h0000_1006, 32'h0, 4'h0, 32'h11BB_33DD, "misaligned");
        idle();
        apply_reset();

        // Abort after one wait cycle.
        address = 32'h0000_1000;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        check("abort bus_error", 32'(bus_error), 32'h1);
        exp_err = 1'b1;
        xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_BEEF, "after abort");
        idle();
        apply_reset();

        // Reset in the middle of a write's wait states.
        address = 32'h0000_1000;
        writedata = 32'h1234_5678;
        byteenable = 4'hF;
        write = 1'b1;
        #1;
        check("midwait waitrequest", 32'(waitrequest), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        write = 1'b0;
        #1;
        check("reset waitrequest low", 32'(waitrequest), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ref_lfsr = 8'hA5;
        exp_err = 1'b0;
        check("reset err", 32'(bus_error), 32'h0);
        xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_BEEF, "write discarded");
        idle();

        // read and write together: no request, no access.
        address = 32'h0000_1000;
        writedata = 32'h0;
        byteenable = 4'hF;
        read = 1'b1;
        write = 1'b1;
        #1;
        check("both waitrequest", 32'(waitrequest), 32'h0);
        check("both readdata", readdata, 32'h0);
        @(negedge clk);
        idle();
        check("both bus_error", 32'(bus_error), 32'h1);
        exp_err = 1'b1;
        xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_BEEF, "both no write");
        idle();
        apply_reset();

        // Address changes mid-transfer: current address is used, error flagged.
        begin
            int w;
            address = 32'h0000_1000;
            read = 1'b1;
            @(negedge clk);
            address = 32'h0000_1004;
            w = 1;
            #1;
            while (waitrequest && w < 40) begin
                w++;
                @(negedge clk);
                #1;
            end
            check("changed waits", 32'(w), 32'(WC));
            check("changed readdata", readdata, 32'h11BB_33DD);
            @(negedge clk);
            check("changed bus_error", 32'(bus_error), 32'h1);
            idle();
        end
`endif
        apply_reset();

        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            mdl_i[i] = wd;
            xfer(1'b1, IB + 32'(i * 4), wd, 4'hF, 32'h0, "preload i");
            wd = $urandom;
            mdl_d[i] = wd;
            xfer(1'b1, DB + 32'(i * 4), wd, 4'hF, 32'h0, "preload d");
        end

        // Back-to-back randomized traffic: request never drops between transfers.
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 7);
            wr = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            if (sel == 7)
                a = 32'h0000_0800 + 32'(idx * 4);
            else
                a = ((sel < 4) ? IB : DB) + 32'(idx * 4);
            if ($urandom_range(0, 7) == 0)
                a = a + 32'($urandom_range(1, 3));
            bad = (sel == 7) || (a[1:0] != 2'b00);
            er = 32'h0;
            if (sel != 7) begin
                old = (sel < 4) ? mdl_i[idx] : mdl_d[idx];
                if (!wr) er = old;
                else begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
                    if (sel < 4) mdl_i[idx] = old;
                    else mdl_d[idx] = old;
                end
            end
            exp_err = exp_err | bad;
            xfer(wr, a, wd, be, er, $sformatf("rand%0d", k));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
